// File: rtl/fir_window_unpack.sv
// fir_window_unpack
//   Converts packed FIR sample windows back into a serial signed sample stream,
//   one sample per output handshake.
//
// Parameters:
//   SAMPLE_W     width of one signed sample
//   NUM_SAMPLES  samples per window (2..16)
//   NEWEST_FIRST 0: oldest slice (bits [SAMPLE_W-1:0]) first; 1: newest (top) slice first
//
// Ports:
//   system1000       clock, rising edge
//   system1000_rstn  asynchronous reset, active low
//   in_valid/in_ready/in_window          window input handshake
//   out_valid/out_ready/out_sample/out_last  sample output handshake
module fir_window_unpack #(
    parameter int SAMPLE_W     = 16,
    parameter int NUM_SAMPLES  = 4,
    parameter int NEWEST_FIRST = 0
) (
    input  logic                            system1000,
    input  logic                            system1000_rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_SAMPLES*SAMPLE_W-1:0] in_window,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SAMPLE_W-1:0]             out_sample,
    output logic                            out_last
);

    localparam int                CNT_W    = $clog2(NUM_SAMPLES);
    localparam int                WIN_W    = NUM_SAMPLES * SAMPLE_W;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIN_W-1:0]   r_hold;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_last;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [WIN_W-1:0]   w_hold_shift;
    logic [SAMPLE_W-1:0] w_sample;

    assign w_last     = (r_state == STREAM) && (r_cnt == LAST_IDX);
    // A new window may enter in the same cycle the final sample leaves,
    // which keeps the stream gap-free across window boundaries.
    assign w_in_ready = (r_state == EMPTY) || (out_ready && w_last);
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = (r_state == STREAM) && out_ready;

    // The emitted slice is always at one end of the hold register; shifting
    // toward that end brings the next sample into position.
    generate
        if (NEWEST_FIRST != 0) begin : g_newest
            assign w_hold_shift = {r_hold[WIN_W-SAMPLE_W-1:0], {SAMPLE_W{1'b0}}};
            assign w_sample     = r_hold[WIN_W-1 -: SAMPLE_W];
        end else begin : g_oldest
            assign w_hold_shift = {{SAMPLE_W{1'b0}}, r_hold[WIN_W-1:SAMPLE_W]};
            assign w_sample     = r_hold[SAMPLE_W-1:0];
        end
    endgenerate

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_state <= EMPTY;
            r_hold  <= '0;
            r_cnt   <= '0;
        end else if (w_in_fire) begin
            r_state <= STREAM;
            r_hold  <= in_window;
            r_cnt   <= '0;
        end else if (w_out_fire) begin
            r_hold <= w_hold_shift;
            if (w_last) begin
                r_state <= EMPTY;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state == STREAM);
    assign out_sample = w_sample;
    assign out_last   = w_last;

endmodule

// File: tb/tb_fir_window_unpack.sv
// tb_fir_window_unpack
//   Drives two instances (oldest-first and newest-first) with identical
//   handshake stimulus. Expected {last, sample} pairs are queued when a window
//   is accepted and compared by a negedge monitor whenever a DUT presents data.
module tb_fir_window_unpack;

    localparam int SW = 16;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [NS*SW-1:0] in_window = '0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, out_last0;
    logic [SW-1:0] out_sample0;
    logic          in_ready1, out_valid1, out_last1;
    logic [SW-1:0] out_sample1;

    int checks = 0;
    int errors = 0;

    logic [SW:0] q0[$];
    logic [SW:0] q1[$];

    always #5 clk = ~clk;

    fir_window_unpack #(.SAMPLE_W(SW), .NUM_SAMPLES(NS), .NEWEST_FIRST(0)) u_dut0 (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready0),
        .in_window       (in_window),
        .out_valid       (out_valid0),
        .out_ready       (out_ready),
        .out_sample      (out_sample0),
        .out_last        (out_last0)
    );

    fir_window_unpack #(.SAMPLE_W(SW), .NUM_SAMPLES(NS), .NEWEST_FIRST(1)) u_dut1 (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready1),
        .in_window       (in_window),
        .out_valid       (out_valid1),
        .out_ready       (out_ready),
        .out_sample      (out_sample1),
        .out_last        (out_last1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a window is a list of NS samples; order depends only on
    // which end is emitted first. Each queue holds what remains of the current
    // window, so readiness follows directly from its occupancy.
    always @(negedge clk) begin
        logic exp_v0, exp_v1, exp_r0, exp_r1;
        if (!rstn) begin
            q0.delete();
            q1.delete();
        end else begin
            exp_v0 = (q0.size() != 0);
            exp_v1 = (q1.size() != 0);
            exp_r0 = (q0.size() == 0) || (out_ready && q0.size() == 1);
            exp_r1 = (q1.size() == 0) || (out_ready && q1.size() == 1);
            chk("out_valid0", {31'd0, out_valid0}, {31'd0, exp_v0});
            chk("out_valid1", {31'd0, out_valid1}, {31'd0, exp_v1});
            chk("in_ready0", {31'd0, in_ready0}, {31'd0, exp_r0});
            chk("in_ready1", {31'd0, in_ready1}, {31'd0, exp_r1});
            if (exp_v0) chk("last_sample0", {15'd0, out_last0, out_sample0}, {15'd0, q0[0]});
            if (exp_v1) chk("last_sample1", {15'd0, out_last1, out_sample1}, {15'd0, q1[0]});
            if (exp_v0 && out_ready) void'(q0.pop_front());
            if (exp_v1 && out_ready) void'(q1.pop_front());
            if (in_valid && exp_r0) begin
                for (int i = 0; i < NS; i++)
                    q0.push_back({(i == NS-1), in_window[i*SW +: SW]});
            end
            if (in_valid && exp_r1) begin
                for (int i = 0; i < NS; i++)
                    q1.push_back({(i == NS-1), in_window[(NS-1-i)*SW +: SW]});
            end
        end
    end

    task automatic send_window(input logic [NS*SW-1:0] w);
        logic acc;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_window = w;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid0"},  {31'd0, out_valid0}, 32'd0);
        chk({tag, "_valid1"},  {31'd0, out_valid1}, 32'd0);
        chk({tag, "_last0"},   {31'd0, out_last0},  32'd0);
        chk({tag, "_sample0"}, {16'd0, out_sample0}, 32'd0);
    endtask

    function automatic logic [SW-1:0] rand_slice();
        case ($urandom_range(0, 7))
            0: rand_slice = 16'h8000;
            1: rand_slice = 16'h7FFF;
            2: rand_slice = 16'hFFFF;
            3: rand_slice = 16'h0000;
            default: rand_slice = SW'($urandom);
        endcase
    endfunction

    function automatic logic [NS*SW-1:0] rand_win();
        logic [NS*SW-1:0] w;
        for (int i = 0; i < NS; i++) w[i*SW +: SW] = rand_slice();
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        // power-on reset across a clock edge
        idle(2);
        rstn = 1'b1;
        idle(2);

        // asynchronous reset asserted mid-clock
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        chk("rst_sample1", {16'd0, out_sample1}, 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        chk("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
        chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
        @(posedge clk);
        #1;

        // single window
        out_ready = 1'b1;
        send_window(64'h0004_0003_0002_0001);
        idle(6);

        // back-to-back windows
        send_window(64'h0004_0003_0002_0001);
        send_window(64'h0008_0007_0006_0005);
        idle(10);

        // backpressure while sample 2 is presented
        send_window(64'h0004_0003_0002_0001);
        idle(1);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        idle(6);

        // sign extremes
        send_window(64'hFFFF_8000_7FFF_0001);
        idle(6);

        // reset after sample 2 has transferred
        send_window(64'h0004_0003_0002_0001);
        @(posedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_window(64'h000D_000C_000B_000A);
        idle(6);

        // randomized traffic with random backpressure
        in_valid  = 1'b1;
        in_window = rand_win();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready0;
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_window = rand_win();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // drain
        while (in_valid) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            out_ready = 1'b1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (q0.size() + q1.size()) != 0; c++) idle(1);
        idle(2);
        chk("drain_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
